// File: rtl/wb_pipe_slice.sv
// ============================================================================
// Module  : wb_pipe_slice
// Brief   : Multi-lane valid/ready pipeline-stage register with 2-entry skid
//           buffer and synchronous flush. Optional perf counters are built
//           when WB_PIPE_SLICE_PERF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_pipe_slice #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_drop_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [LANES*DATA_W-1:0]   w_in_masked;
  logic [LANES*DATA_W-1:0]   r_main_data;
  logic [LANES*DATA_W-1:0]   r_skid_data;
  logic [LANES*DATA_W-1:0]   w_main_data_nxt;
  logic [LANES*DATA_W-1:0]   w_skid_data_nxt;
  logic [LANES-1:0]          r_main_lv;
  logic [LANES-1:0]          r_skid_lv;
  logic [LANES-1:0]          w_main_lv_nxt;
  logic [LANES-1:0]          w_skid_lv_nxt;
  logic                      r_in_ready;
  logic                      w_accept;
  logic                      w_drain;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_in_masked[gi*DATA_W +: DATA_W] =
        in_lane_valid[gi] ? in_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  assign out_valid      = (r_state != S_EMPTY);
  assign out_data       = r_main_data;
  assign out_lane_valid = r_main_lv;
  assign in_ready       = r_in_ready;
  assign w_accept       = in_valid && r_in_ready;
  assign w_drain        = out_valid && out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_lv_nxt   = r_main_lv;
    w_skid_data_nxt = r_skid_data;
    w_skid_lv_nxt   = r_skid_lv;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = S_ONE;
          w_main_data_nxt = w_in_masked;
          w_main_lv_nxt   = in_lane_valid;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_main_data_nxt = w_in_masked;
          w_main_lv_nxt   = in_lane_valid;
        end else if (w_accept) begin
          w_state_nxt     = S_TWO;
          w_skid_data_nxt = w_in_masked;
          w_skid_lv_nxt   = in_lane_valid;
        end else if (w_drain) begin
          w_state_nxt     = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only a drain can move the state
        if (w_drain) begin
          w_state_nxt     = S_ONE;
          w_main_data_nxt = r_skid_data;
          w_main_lv_nxt   = r_skid_lv;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt     = S_EMPTY;
      w_main_data_nxt = '0;
      w_main_lv_nxt   = '0;
      w_skid_data_nxt = '0;
      w_skid_lv_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_lv   <= '0;
      r_skid_data <= '0;
      r_skid_lv   <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_lv   <= w_main_lv_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_lv   <= w_skid_lv_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
    end
  end

`ifdef WB_PIPE_SLICE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_drop_cnt;
  logic [1:0]       w_held;

  // entries drained in the flush cycle still reach downstream, so they are not drops
  always_comb begin
    w_held = 2'd0;
    case (r_state)
      S_ONE:   w_held = w_drain ? 2'd0 : 2'd1;
      S_TWO:   w_held = w_drain ? 2'd1 : 2'd2;
      default: w_held = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt      <= '0;
      r_flush_drop_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush)
        r_flush_drop_cnt <= r_flush_drop_cnt + CNT_W'(w_held);
    end
  end

  assign stall_cnt      = r_stall_cnt;
  assign flush_drop_cnt = r_flush_drop_cnt;
`else
  assign stall_cnt      = '0;
  assign flush_drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_pipe_slice.sv
// ============================================================================
// Module  : tb_wb_pipe_slice
// Brief   : Directed self-checking bench for wb_pipe_slice (LANES=2, CNT_W=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_pipe_slice;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_lane_valid;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane_valid;
  logic [63:0] out_data;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_drop_cnt;

  int n_total = 0;
  int n_bad   = 0;

  wb_pipe_slice #(
    .DATA_W (32),
    .LANES  (2),
    .CNT_W  (4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_data       (out_data),
    .stall_cnt      (stall_cnt),
    .flush_drop_cnt (flush_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] lv, input logic [63:0] d);
    in_valid      = v;
    in_lane_valid = lv;
    in_data       = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 64'h0);
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_lv", 64'(out_lane_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(flush_drop_cnt), 64'd0);
    rst = 1'b0;
    step();

    // T1: basic transfer and full-rate streaming
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 64'h0000000B_0000000A);
    step();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", out_data, 64'h0000000B_0000000A);
    drive(1'b1, 2'b11, 64'h0000000D_0000000C);
    step();
    chk("t1_stream1", out_data, 64'h0000000D_0000000C);
    chk("t1_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 2'b11, 64'h0000000F_0000000E);
    step();
    chk("t1_stream2", out_data, 64'h0000000F_0000000E);
    drive(1'b0, 2'b00, 64'h0);
    step();
    chk("t1_empty", 64'(out_valid), 64'd0);

    // T2: stall with skid fill, then ordered drain
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h000001A1_000000A0);
    step();
    chk("t2_a_out", out_data, 64'h000001A1_000000A0);
    chk("t2_ready_one", 64'(in_ready), 64'd1);
    drive(1'b1, 2'b11, 64'h000001B1_000000B0);
    step();
    chk("t2_ready_two", 64'(in_ready), 64'd0);
    chk("t2_a_held", out_data, 64'h000001A1_000000A0);
    drive(1'b1, 2'b11, 64'h000001C1_000000C0);
    step();
    chk("t2_a_still", out_data, 64'h000001A1_000000A0);
    chk("t2_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("t2_b_out", out_data, 64'h000001B1_000000B0);
    chk("t2_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("t2_c_out", out_data, 64'h000001C1_000000C0);
    drive(1'b0, 2'b00, 64'h0);
    step();
    chk("t2_empty", 64'(out_valid), 64'd0);

    // T3: lane masking
    drive(1'b1, 2'b01, 64'hFFFFFFFF_00000005);
    step();
    chk("t3_lv", 64'(out_lane_valid), 64'd1);
    chk("t3_data", out_data, 64'h00000000_00000005);
    // bubble entry: all lanes invalid still handshakes
    drive(1'b1, 2'b00, 64'h00000001_00000002);
    step();
    chk("bub_valid", 64'(out_valid), 64'd1);
    chk("bub_data", out_data, 64'h0);
    drive(1'b0, 2'b00, 64'h0);
    step();
    chk("bub_empty", 64'(out_valid), 64'd0);

    // T4: flush while TWO with an input offered
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h00000011_00000010);
    step();
    drive(1'b1, 2'b11, 64'h00000021_00000020);
    step();
    chk("t4_two", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 2'b11, 64'h00000031_00000030);
    step();
    flush = 1'b0;
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_data", out_data, 64'h0);
    chk("t4_ready", 64'(in_ready), 64'd1);
`ifdef WB_PIPE_SLICE_PERF_EN
    chk("t4_drop2", 64'(flush_drop_cnt), 64'd2);
`else
    chk("t4_drop0", 64'(flush_drop_cnt), 64'd0);
`endif
    drive(1'b0, 2'b00, 64'h0);
    out_ready = 1'b1;
    step();
    chk("t4_nothing1", 64'(out_valid), 64'd0);
    step();
    chk("t4_nothing2", 64'(out_valid), 64'd0);
    // flush coinciding with a drain: the drained entry is not a drop
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h00000041_00000040);
    step();
    drive(1'b0, 2'b00, 64'h0);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4b_valid", 64'(out_valid), 64'd0);
`ifdef WB_PIPE_SLICE_PERF_EN
    chk("t4b_drop", 64'(flush_drop_cnt), 64'd2);
`else
    chk("t4b_drop", 64'(flush_drop_cnt), 64'd0);
`endif

    // T5: asynchronous reset mid-cycle
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h00000051_00000050);
    step();
    drive(1'b0, 2'b00, 64'h0);
    chk("t5_pre", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    chk("t5_data", out_data, 64'h0);
    chk("t5_stall_clr", 64'(stall_cnt), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 64'h00000061_00000060);
    step();
    chk("t5_resume", out_data, 64'h00000061_00000000);
    drive(1'b0, 2'b00, 64'h0);
    step();

    // T6: stall counter wraps (17 stalled cycles mod 16)
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h00000071_00000070);
    step();
    drive(1'b0, 2'b00, 64'h0);
    repeat (17) step();
    chk("t6_held", out_data, 64'h00000071_00000070);
`ifdef WB_PIPE_SLICE_PERF_EN
    chk("t6_wrap", 64'(stall_cnt), 64'd1);
`else
    chk("t6_tied", 64'(stall_cnt), 64'd0);
`endif
    out_ready = 1'b1;
    step();
    chk("t6_drain", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
